// File: rtl/delay_meter.sv
// Multi-channel path-delay meter: launches a transition into one path, counts
// cycles until the synchronised path output follows, repeats and accumulates stats.
module delay_meter #(
    parameter int             CNT_W = 32,
    parameter int             SUM_W = 40,
    parameter int             CH    = 4,
    parameter int             CH_W  = 2,
    parameter int             TR_W  = 8,
    parameter int             GAP   = 4,
    parameter logic [CH-1:0]  INV   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   chSel,
    input  logic [TR_W-1:0]   trials,
    input  logic [CNT_W-1:0]  timeout,
    input  logic [CH-1:0]     pathResult,
    output logic [CH-1:0]     pathInput,
    output logic [SUM_W-1:0]  result,
    output logic [CNT_W-1:0]  minCount,
    output logic [CNT_W-1:0]  maxCount,
    output logic [TR_W-1:0]   trialsDone,
    output logic              busy,
    output logic              done,
    output logic              timedOut,
    output logic              overflow
);

    localparam int NSEL = 1 << CH_W;
    localparam int AW   = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
    localparam int GW   = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_LAUNCH, S_MEASURE, S_GAP, S_DONE
    } state_t;

    state_t             state;
    logic [CH-1:0]      sync1, sync2;
    logic [CH_W-1:0]    ch;
    logic [TR_W-1:0]    trials_q;
    logic [CNT_W-1:0]   timeout_q;
    logic [CNT_W-1:0]   cnt;
    logic [GW-1:0]      gap_cnt;

    logic [NSEL-1:0]    sync_ext, pin_ext, inv_ext;
    logic               ch_ok, match, tmo_hit, sum_sat;
    logic [CNT_W-1:0]   cnt_inc;
    logic [AW-1:0]      sum_w;
    logic [CH-1:0]      toggle;

    // Widen per-channel vectors so an out-of-range chSel indexes safely.
    always_comb begin
        sync_ext         = '0;
        pin_ext          = '0;
        inv_ext          = '0;
        sync_ext[CH-1:0] = sync2;
        pin_ext[CH-1:0]  = pathInput;
        inv_ext[CH-1:0]  = INV;
    end

    assign ch_ok   = (32'(ch) < CH);
    assign match   = (sync_ext[ch] == (pin_ext[ch] ^ inv_ext[ch]));
    assign tmo_hit = (timeout_q != '0) && (cnt >= timeout_q);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign sum_w   = AW'(result) + AW'(cnt);
    assign sum_sat = (sum_w > AW'({SUM_W{1'b1}}));
    assign toggle  = CH'(1) << ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sync1      <= '0;
            sync2      <= '0;
            ch         <= '0;
            trials_q   <= '0;
            timeout_q  <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            pathInput  <= '0;
            result     <= '0;
            minCount   <= '1;
            maxCount   <= '0;
            trialsDone <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timedOut   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1 <= pathResult;
            sync2 <= sync1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch         <= chSel;
                        trials_q   <= (trials == '0) ? TR_W'(1) : trials;
                        timeout_q  <= timeout;
                        cnt        <= '0;
                        result     <= '0;
                        trialsDone <= '0;
                        maxCount   <= '0;
                        minCount   <= '1;
                        timedOut   <= 1'b0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_PREP;
                    end
                end
                // Wait for the path to agree with its current drive before launching.
                S_PREP: begin
                    if (!ch_ok || (!match && tmo_hit)) begin
                        timedOut <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else if (match) begin
                        state <= S_LAUNCH;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_LAUNCH: begin
                    pathInput <= pathInput ^ toggle;
                    cnt       <= '0;
                    state     <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (match) begin
                        result     <= sum_sat ? '1 : sum_w[SUM_W-1:0];
                        overflow   <= overflow | sum_sat;
                        minCount   <= (cnt < minCount) ? cnt : minCount;
                        maxCount   <= (cnt > maxCount) ? cnt : maxCount;
                        trialsDone <= trialsDone + 1'b1;
                        if (trialsDone + 1'b1 == trials_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (tmo_hit) begin
                        timedOut <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) state <= S_LAUNCH;
                    else                         gap_cnt <= gap_cnt + 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: main instance (CH_W=3, INV[2]=1) plus a
// narrow-sum instance for saturation.
module tb_delay_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  chSel;
    logic [7:0]  trials;
    logic [31:0] timeout;
    logic [3:0]  pathResult, pathInput;
    logic [39:0] result;
    logic [31:0] minCount, maxCount;
    logic [7:0]  trialsDone;
    logic        busy, done, timedOut, overflow;

    logic        start_s;
    logic [3:0]  pres_s, pin_s;
    logic [3:0]  result_s;
    logic [31:0] min_s, max_s;
    logic [7:0]  tdone_s;
    logic        busy_s, done_s, tmo_s, ovf_s;

    logic [4:0]  dly5  = '0;
    logic [9:0]  dly10 = '0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dly5  <= {dly5[3:0], pathInput[2]};
        dly10 <= {dly10[8:0], pin_s[0]};
        if (done) n_done <= n_done + 1;
    end

    // ch0: wire, ch1: stuck low, ch2: inverting 5-cycle delay, ch3: stuck low
    assign pathResult = {1'b0, ~dly5[4], 1'b0, pathInput[0]};
    assign pres_s     = {3'b000, dly10[9]};

    delay_meter #(.CH_W(3), .INV(4'b0100)) u_dut (
        .clk(clk), .rst(rst), .start(start), .chSel(chSel), .trials(trials),
        .timeout(timeout), .pathResult(pathResult), .pathInput(pathInput),
        .result(result), .minCount(minCount), .maxCount(maxCount),
        .trialsDone(trialsDone), .busy(busy), .done(done),
        .timedOut(timedOut), .overflow(overflow));

    delay_meter #(.SUM_W(4)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_s), .chSel(2'd0), .trials(8'd2),
        .timeout(32'd0), .pathResult(pres_s), .pathInput(pin_s),
        .result(result_s), .minCount(min_s), .maxCount(max_s),
        .trialsDone(tdone_s), .busy(busy_s), .done(done_s),
        .timedOut(tmo_s), .overflow(ovf_s));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic launch(input logic [2:0] c, input logic [7:0] t, input logic [31:0] to);
        @(negedge clk);
        chSel = c; trials = t; timeout = to; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pin"},  64'(pathInput), 64'd0);
        chk({tag, "_res"},  64'(result), 64'd0);
        chk({tag, "_min"},  64'(minCount), 64'hFFFF_FFFF);
        chk({tag, "_max"},  64'(maxCount), 64'd0);
        chk({tag, "_td"},   64'(trialsDone), 64'd0);
        chk({tag, "_flags"}, 64'({busy, done, timedOut, overflow}), 64'd0);
    endtask

    initial begin
        int nd0, k;
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        chSel = '0; trials = '0; timeout = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // ch0 zero-delay path, 4 trials
        nd0 = n_done;
        launch(3'd0, 8'd4, 32'd0);
        wait_done("t1_done");
        chk("t1_result", 64'(result), 64'd8);
        chk("t1_min",    64'(minCount), 64'd2);
        chk("t1_max",    64'(maxCount), 64'd2);
        chk("t1_td",     64'(trialsDone), 64'd4);
        chk("t1_tmo",    64'(timedOut), 64'd0);
        @(negedge clk);
        chk("t1_end", 64'({busy, done}), 64'd0);
        chk("t1_pulses", 64'(n_done - nd0), 64'd1);
        chk("t1_pin", 64'(pathInput), 64'd0);

        // ch2 inverted, 5-cycle delay, 3 trials
        launch(3'd2, 8'd3, 32'd0);
        wait_done("t2_done");
        chk("t2_result", 64'(result), 64'd21);
        chk("t2_min",    64'(minCount), 64'd7);
        chk("t2_max",    64'(maxCount), 64'd7);
        chk("t2_td",     64'(trialsDone), 64'd3);
        chk("t2_pin",    64'(pathInput), 64'b0100);
        @(negedge clk);

        // ch1 stuck low, timeout
        launch(3'd1, 8'd2, 32'd10);
        wait_done("t3_done");
        chk("t3_tmo",    64'(timedOut), 64'd1);
        chk("t3_td",     64'(trialsDone), 64'd0);
        chk("t3_result", 64'(result), 64'd0);
        chk("t3_pin",    64'(pathInput), 64'b0110);
        @(negedge clk);

        // bad channel: done in the second cycle after the start edge
        launch(3'd5, 8'd1, 32'd0);
        chk("t6_nodone_s1", 64'(done), 64'd0);
        @(negedge clk);
        chk("t6_done_s2", 64'(done), 64'd1);
        chk("t6_tmo",     64'(timedOut), 64'd1);
        chk("t6_td",      64'(trialsDone), 64'd0);
        chk("t6_pin",     64'(pathInput), 64'b0110);
        @(negedge clk);
        chk("t6_idle", 64'({busy, done}), 64'd0);

        // reset during trial 2 measurement
        launch(3'd2, 8'd3, 32'd0);
        k = 0;
        while (trialsDone != 8'd1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t5_trial1", 64'(trialsDone), 64'd1);
        repeat (7) @(negedge clk);
        chk("t5_measuring", 64'({busy, trialsDone}), 64'h101);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t5_rst");
        rst = 1'b0;
        @(negedge clk);
        launch(3'd0, 8'd0, 32'd0);
        wait_done("t5b_done");
        chk("t5b_td",     64'(trialsDone), 64'd1);
        chk("t5b_result", 64'(result), 64'd2);
        chk("t5b_minmax", 64'({minCount, maxCount}), {32'd2, 32'd2});

        // narrow sum saturation: 10-cycle path -> 12 per trial
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        k = 0;
        while (!done_s && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t4_done",   64'(done_s), 64'd1);
        chk("t4_result", 64'(result_s), 64'd15);
        chk("t4_ovf",    64'(ovf_s), 64'd1);
        chk("t4_max",    64'(max_s), 64'd12);
        chk("t4_min",    64'(min_s), 64'd12);
        chk("t4_td",     64'(tdone_s), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
